// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped line-fill data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        FILL,
        WRITE
    } state_t;

    localparam int LINE_BYTES     = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int OFFSET_BITS    = 5;
    localparam int LINE_BITS      = LINE_BYTES * 8;

    // Replace the bytes of old_word selected by mask with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid bits and tags for the data cache: one combinational read port, one write
// port. Valid bits clear asynchronously; tags need no reset because valid gates them.
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int LINE_COUNT = 16,
    parameter int TAG_BITS   = 23,
    localparam int INDEX_BITS = $clog2(LINE_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag
);

    logic [LINE_COUNT-1:0] valid;
    logic [TAG_BITS-1:0]   tags [LINE_COUNT];

    // A line becomes valid only when its refill completes; reset invalidates everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag storage, written alongside the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];

endmodule

// File: rtl/dcache_line_fill.sv
// Direct-mapped, write-through, no-write-allocate data cache with 256-bit line refill.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_line_fill
    import dcache_pkg::*;
#(
    parameter int LINE_COUNT = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [31:0]           cpu_write_data,
    input  logic [3:0]            cpu_write_mask,
    output logic [31:0]           cpu_read_data,
    output logic                  cpu_ready,
    output logic                  cpu_busy,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic [3:0]            mem_write_mask,
`ifdef DCACHE_STATS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    input  logic [LINE_BITS-1:0]  mem_read_data
);

    localparam int INDEX_BITS = $clog2(LINE_COUNT);
    localparam int TAG_BITS   = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

    state_t state;
    state_t next_state;

    logic                  req_write;
    logic [ADDR_WIDTH-1:2] req_word_address;
    logic [31:0]           req_data;
    logic [3:0]            req_mask;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [2:0]            req_word_sel;

    logic                  tag_valid;
    logic [TAG_BITS-1:0]   tag_stored;
    logic                  hit;

    logic [LINE_BITS-1:0]  line_data [LINE_COUNT];
    logic [31:0]           cached_word;

    logic                  unused_address_bits;

    assign unused_address_bits = ^cpu_address[1:0];

    assign req_index    = req_word_address[OFFSET_BITS +: INDEX_BITS];
    assign req_tag      = req_word_address[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_word_sel = req_word_address[4:2];

    dcache_tag_array #(
        .LINE_COUNT (LINE_COUNT),
        .TAG_BITS   (TAG_BITS)
    ) tag_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (req_index),
        .rd_valid (tag_valid),
        .rd_tag   (tag_stored),
        .wr_en    (state == FILL),
        .wr_index (req_index),
        .wr_tag   (req_tag)
    );

    assign hit         = tag_valid && (tag_stored == req_tag);
    assign cached_word = line_data[req_index][{req_word_sel, 5'b00000} +: 32];
    assign cpu_busy    = (state != IDLE);

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: lookup decides between an immediate hit, a line refill or a write-through.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cpu_req) next_state = LOOKUP;
            LOOKUP:  begin
                if (req_write)  next_state = WRITE;
                else if (hit)   next_state = IDLE;
                else            next_state = REFILL;
            end
            REFILL:  next_state = FILL;
            FILL:    next_state = IDLE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request once in IDLE so later states never look at the cpu_* inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_write        <= 1'b0;
            req_word_address <= '0;
            req_data         <= '0;
            req_mask         <= '0;
        end else if (state == IDLE && cpu_req) begin
            req_write        <= cpu_write;
            req_word_address <= cpu_address[ADDR_WIDTH-1:2];
            req_data         <= cpu_write_data;
            req_mask         <= cpu_write_mask;
        end
    end

    // Completion pulse and load data; read data holds between completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ready     <= 1'b0;
            cpu_read_data <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                LOOKUP: begin
                    if (!req_write && hit) begin
                        cpu_ready     <= 1'b1;
                        cpu_read_data <= cached_word;
                    end
                end
                FILL: begin
                    cpu_ready     <= 1'b1;
                    cpu_read_data <= mem_read_data[{req_word_sel, 5'b00000} +: 32];
                end
                WRITE: begin
                    cpu_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Line storage: whole-line refill, or byte merge on a store that hits.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            line_data[req_index] <= mem_read_data;
        end else if (state == WRITE && hit) begin
            line_data[req_index][{req_word_sel, 5'b00000} +: 32] <=
                merge_bytes(cached_word, req_data, req_mask);
        end
    end

    // Memory-side outputs are decoded from state and the latched request only.
    always_comb begin
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_mask   = '0;
        case (state)
            REFILL, FILL: begin
                mem_address = {req_word_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                mem_address      = {req_word_address, 2'b00};
                mem_write_data   = req_data;
                mem_write_mask   = req_mask;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    // Every lookup bumps exactly one saturating counter; stores are classified too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_line_fill.sv
// Testbench for dcache_line_fill: directed scenarios followed by random loads/stores,
// checked against a word-level memory image and a valid/tag hit model.
module tb_dcache_line_fill;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_address = '0;
    logic [31:0]  cpu_write_data = '0;
    logic [3:0]   cpu_write_mask = '0;
    logic [31:0]  cpu_read_data;
    logic         cpu_ready;
    logic         cpu_busy;
    logic         mem_write_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_write_data;
    logic [3:0]   mem_write_mask;
    logic [255:0] mem_read_data = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_words [0:4095];
    logic [31:0] ref_words [0:4095];
    bit          model_valid [16];
    logic [31:0] model_tag [16];
    int          model_hits = 0;
    int          model_misses = 0;

    dcache_line_fill dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_req          (cpu_req),
        .cpu_write        (cpu_write),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_write_mask   (cpu_write_mask),
        .cpu_read_data    (cpu_read_data),
        .cpu_ready        (cpu_ready),
        .cpu_busy         (cpu_busy),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_mask   (mem_write_mask),
`ifdef DCACHE_STATS_EN
        .hit_count        (hit_count),
        .miss_count       (miss_count),
`endif
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] line_at(input logic [31:0] a);
        logic [255:0] l;
        int base;
        base = int'(a[13:5]) * 8;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_words[base + w];
        return l;
    endfunction

    // Block-read data memory: registered line read, byte-masked word write.
    always @(posedge clk) begin
        logic [31:0] merged;
        if (mem_write_enable) begin
            merged = mem_words[mem_address[13:2]];
            for (int b = 0; b < 4; b++)
                if (mem_write_mask[b]) merged[b*8 +: 8] = mem_write_data[b*8 +: 8];
            mem_words[mem_address[13:2]] <= merged;
        end
        mem_read_data <= line_at(mem_address);
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
        model_hits = 0;
        model_misses = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // One complete CPU access starting at a falling edge; checks latency, data and memory traffic.
    task automatic apply_stimulus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] m);
        int          idx;
        logic [31:0] tg;
        bit          exp_hit;
        int          exp_lat;
        int          ready_cycle;
        logic [31:0] rdata;
        int          we_pulses;
        logic [31:0] w_addr, w_data, refill_addr;
        logic [3:0]  w_mask;
        logic        busy1, busy_ready;
        logic [31:0] exp_word;

        idx = int'((a >> 5) & 32'd15);
        tg  = a >> 9;
        exp_hit = model_valid[idx] && (model_tag[idx] == tg);
        if (exp_hit) model_hits++; else model_misses++;
        exp_lat = wr ? 3 : (exp_hit ? 2 : 4);

        cpu_req = 1'b1;
        cpu_write = wr;
        cpu_address = a;
        cpu_write_data = d;
        cpu_write_mask = m;
        @(posedge clk);
        #1 cpu_req = 1'b0;

        ready_cycle = -1;
        rdata = '0;
        we_pulses = 0;
        w_addr = '0; w_data = '0; w_mask = '0; refill_addr = '0;
        busy1 = 1'b0; busy_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = cpu_busy;
            if (c == 2) refill_addr = mem_address;
            if (mem_write_enable) begin
                we_pulses++;
                w_addr = mem_address; w_data = mem_write_data; w_mask = mem_write_mask;
            end
            if (cpu_ready) begin
                ready_cycle = c;
                rdata = cpu_read_data;
                busy_ready = cpu_busy;
                break;
            end
        end

        check("latency", ready_cycle, exp_lat);
        check("busy_in_lookup", busy1, 1'b1);
        check("busy_at_ready", busy_ready, 1'b0);
        if (wr) begin
            check("write_pulses", we_pulses, 1);
            check("write_address", w_addr, {a[31:2], 2'b00});
            check("write_data", w_data, d);
            check("write_mask", w_mask, m);
            exp_word = ref_words[a[13:2]];
            for (int b = 0; b < 4; b++) if (m[b]) exp_word[b*8 +: 8] = d[b*8 +: 8];
            ref_words[a[13:2]] = exp_word;
        end else begin
            check("load_no_write", we_pulses, 0);
            check("load_data", rdata, ref_words[a[13:2]]);
            if (!exp_hit) begin
                check("refill_address", refill_addr, {a[31:5], 5'b00000});
                model_valid[idx] = 1'b1;
                model_tag[idx] = tg;
            end
        end
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, model_hits);
        check("miss_count", miss_count, model_misses);
`endif
    endtask

    // Outputs that must all read zero while reset holds the design idle.
    task automatic check_output_reset();
        check("rst_ready", cpu_ready, 1'b0);
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_rdata", cpu_read_data, 32'h0);
        check("rst_we", mem_write_enable, 1'b0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        check("rst_wmask", mem_write_mask, 4'h0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 4096; i++) begin
            mem_words[i] = $urandom;
            ref_words[i] = mem_words[i];
        end
        for (int k = 0; k < 8; k++) begin
            mem_words[32'h40 + k] = 32'h11111111 * (k + 1);
            ref_words[32'h40 + k] = 32'h11111111 * (k + 1);
        end
        clear_model();

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        check_output_reset();
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed scenarios");
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'h0);
        check("first_load_value", cpu_read_data, 32'h11111111);
        apply_stimulus(1'b0, 32'h104, 32'h0, 4'h0);
        check("hit_load_value", cpu_read_data, 32'h22222222);
        apply_stimulus(1'b1, 32'h104, 32'hAABBCCDD, 4'b0011);
        apply_stimulus(1'b0, 32'h104, 32'h0, 4'h0);
        check("merged_value", cpu_read_data, 32'h2222CCDD);
        apply_stimulus(1'b1, 32'h108, 32'h12345678, 4'b0000);
        apply_stimulus(1'b0, 32'h108, 32'h0, 4'h0);
        check("zero_mask_value", cpu_read_data, 32'h33333333);
        apply_stimulus(1'b1, 32'h2000, 32'hCAFEF00D, 4'b1111);
        apply_stimulus(1'b0, 32'h2000, 32'h0, 4'h0);
        check("store_miss_value", cpu_read_data, 32'hCAFEF00D);

        $display("[TB] conflict eviction");
        apply_reset();
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'h0);
        apply_stimulus(1'b0, 32'h300, 32'h0, 4'h0);
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'h0);
        check("conflict_misses", model_misses, 3);
`ifdef DCACHE_STATS_EN
        check("conflict_miss_count", miss_count, 32'd3);
        check("conflict_hit_count", hit_count, 32'd0);
`endif

        $display("[TB] reset during refill");
        apply_reset();
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 32'h100;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("refill_busy", cpu_busy, 1'b1);
        check("refill_addr_direct", mem_address, 32'h100);
        reset = 1'b1;
        #1;
        check_output_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5)
              | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0)
                apply_stimulus(1'b1, a, $urandom, 4'($urandom_range(0, 15)));
            else
                apply_stimulus(1'b0, a, 32'h0, 4'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
